// File: rtl/nl_lut_loader_if.sv
// -----------------------------------------------------------------------------
// nl_lut_loader_if
// Bus bundle between the LUT loader and its two neighbours: the parameter
// memory (read strobe, word address, read data returned one cycle later) and
// the nonlinear unit's external LUT write port (strobe, entry address, data).
//   master : the loader side (drives the read request and the LUT write port)
//   slave  : the memory / LUT side (returns read data, receives the writes)
// -----------------------------------------------------------------------------
interface nl_lut_loader_if #(
    parameter int LUT_ADDR       = 6,
    parameter int LUT_DATA_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR       = 10
);
    logic                      mem_rd_en;
    logic [MEM_ADDR-1:0]       mem_rd_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_rd_data;
    logic                      wr_en_ext_lut;
    logic [LUT_ADDR-1:0]       wr_addr_ext_lut;
    logic [LUT_DATA_WIDTH-1:0] wr_data_ext_lut;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  wr_en_ext_lut, wr_addr_ext_lut, wr_data_ext_lut
    );
endinterface

// File: rtl/nl_lut_loader.sv
// -----------------------------------------------------------------------------
// nl_lut_loader
// Config stage for the sigmoid/tanh nonlinear unit. A start pulse latches a
// base word address and an entry count (clamped to LUT_SIZE); the loader then
// fetches packed words from parameter memory, splits each into EPW signed
// entries (lowest slice first) and writes them one per cycle into the LUT.
// Writes stall while the nonlinear unit is running; memory fetches do not.
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   start_load_i             one-cycle request, honoured only in IDLE
//   base_addr_i              memory word address of entry 0
//   num_entries_i            entries to load
//   enable_nonlinear_block_i high = nonlinear unit active, LUT writes hold
//   bus                      memory read port + LUT write port (master)
//   busy_o                   high whenever not IDLE
//   load_done_o              one-cycle pulse after the last write / empty load
// -----------------------------------------------------------------------------
module nl_lut_loader #(
    parameter int LUT_ADDR       = 6,
    parameter int LUT_SIZE       = 58,
    parameter int LUT_DATA_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR       = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_load_i,
    input  logic [MEM_ADDR-1:0] base_addr_i,
    input  logic [LUT_ADDR:0]   num_entries_i,
    input  logic                enable_nonlinear_block_i,
    nl_lut_loader_if.master     bus,
    output logic                busy_o,
    output logic                load_done_o
);
    localparam int EPW   = MEM_DATA_WIDTH / LUT_DATA_WIDTH;
    localparam int SUB_W = (EPW > 1) ? $clog2(EPW) : 1;
    localparam logic [SUB_W-1:0]  LAST_SUB = SUB_W'(EPW - 1);
    localparam logic [LUT_ADDR:0] MAX_CNT  = (LUT_ADDR + 1)'(LUT_SIZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UNPACK = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                state_q,    state_d;
    logic [MEM_ADDR-1:0]       base_q,     base_d;
    logic [LUT_ADDR:0]         cnt_q,      cnt_d;
    logic [LUT_ADDR:0]         entry_q,    entry_d;
    logic [MEM_ADDR-1:0]       word_idx_q, word_idx_d;
    logic [SUB_W-1:0]          sub_q,      sub_d;
    logic [MEM_DATA_WIDTH-1:0] word_q,     word_d;

    logic [LUT_ADDR:0]         cnt_clamped;
    logic [LUT_ADDR:0]         entry_inc;
    logic                      wr_fire;
    logic [LUT_DATA_WIDTH-1:0] slices [EPW];

    // Word split into its entries; slice 0 is the least significant one.
    for (genvar gi = 0; gi < EPW; gi++) begin : g_slice
        assign slices[gi] = word_q[gi*LUT_DATA_WIDTH +: LUT_DATA_WIDTH];
    end

    assign cnt_clamped = (num_entries_i > MAX_CNT) ? MAX_CNT : num_entries_i;
    assign entry_inc   = entry_q + 1'b1;
    assign wr_fire     = (state_q == S_UNPACK) && !enable_nonlinear_block_i;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        entry_d    = entry_q;
        word_idx_d = word_idx_q;
        sub_d      = sub_q;
        word_d     = word_q;
        case (state_q)
            S_IDLE: begin
                if (start_load_i) begin
                    base_d     = base_addr_i;
                    cnt_d      = cnt_clamped;
                    entry_d    = '0;
                    word_idx_d = '0;
                    sub_d      = '0;
                    state_d    = (cnt_clamped == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                word_d  = bus.mem_rd_data;
                state_d = S_UNPACK;
            end
            S_UNPACK: begin
                // While stalled nothing moves; the current entry stays presented.
                if (wr_fire) begin
                    entry_d = entry_inc;
                    if (entry_inc == cnt_q) begin
                        state_d = S_DONE;
                    end else if (sub_q == LAST_SUB) begin
                        sub_d      = '0;
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            entry_q    <= '0;
            word_idx_q <= '0;
            sub_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            entry_q    <= entry_d;
            word_idx_q <= word_idx_d;
            sub_q      <= sub_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        bus.mem_rd_en       = 1'b0;
        bus.mem_rd_addr     = '0;
        bus.wr_en_ext_lut   = 1'b0;
        bus.wr_addr_ext_lut = '0;
        bus.wr_data_ext_lut = '0;
        if (state_q == S_REQ) begin
            bus.mem_rd_en   = 1'b1;
            bus.mem_rd_addr = base_q + word_idx_q;   // wraps modulo 2^MEM_ADDR
        end
        if (state_q == S_UNPACK) begin
            bus.wr_en_ext_lut   = !enable_nonlinear_block_i;
            bus.wr_addr_ext_lut = entry_q[LUT_ADDR-1:0];
            bus.wr_data_ext_lut = slices[sub_q];
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign load_done_o = (state_q == S_DONE);
endmodule
